// File: rtl/pid_plant_spi_slave_if.sv
// Plant-side SPI bus: one shared sck, separate selects for PV reads and stimulus writes.
interface pid_plant_spi_slave_if;
    logic sck;
    logic in_cs_n;
    logic out_cs_n;
    logic mosi;
    logic miso;

    modport master (output sck, in_cs_n, out_cs_n, mosi, input miso);
    modport slave  (input sck, in_cs_n, out_cs_n, mosi, output miso);
endinterface

// File: rtl/pid_plant_spi_slave.sv
// SPI responder holding a first-order plant model: serves PV reads, accepts stimulus writes,
// and steps PV toward the stimulus after each accepted write.
//
// state     | meaning
// RD_IDLE   | no PV read frame active
// RD_SHIFT  | PV read frame active, shifting tx out on miso
// WR_IDLE   | no stimulus write frame active
// WR_SHIFT  | stimulus write frame active, shifting mosi into rx
// WR_ABORT  | write frame killed by a collision, waiting for out_cs_n to rise
module pid_plant_spi_slave #(
    parameter int WIDTH       = 4,
    parameter int SHIFT       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pid_plant_spi_slave_if.slave bus,
    input  logic [WIDTH-1:0]     pv_init,
    output logic [WIDTH-1:0]     pv,
    output logic [WIDTH-1:0]     stim,
    output logic                 rd_done,
    output logic                 wr_done,
    output logic                 err
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    localparam logic [0:0] RD_IDLE  = 1'b0;
    localparam logic [0:0] RD_SHIFT = 1'b1;
    localparam logic [1:0] WR_IDLE  = 2'd0;
    localparam logic [1:0] WR_SHIFT = 2'd1;
    localparam logic [1:0] WR_ABORT = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync, in_sync, out_sync, mosi_sync;
    logic sck_s, in_s, out_s, mosi_s;
    logic sck_q, in_q, out_q;
    logic sck_rise, in_fall, in_rise, out_fall, out_rise;

    logic [0:0]       rd_state;
    logic [1:0]       wr_state;
    logic [CW-1:0]    rd_cnt, wr_cnt;
    logic [WIDTH-1:0] tx, rx;
    logic             collision, rd_bad, wr_bad;
    logic signed [WIDTH:0] diff, step;

    // Selects reset to "asserted" so a frame left running across reset never shows a falling
    // edge; it is ignored until its select returns high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '1;
            in_sync   <= '0;
            out_sync  <= '0;
            mosi_sync <= '0;
            sck_q     <= 1'b1;
            in_q      <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            in_sync   <= {in_sync[SYNC_STAGES-2:0], bus.in_cs_n};
            out_sync  <= {out_sync[SYNC_STAGES-2:0], bus.out_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sck_q     <= sck_s;
            in_q      <= in_s;
            out_q     <= out_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign in_s     = in_sync[SYNC_STAGES-1];
    assign out_s    = out_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_q;
    assign in_fall  = in_q & ~in_s;
    assign in_rise  = ~in_q & in_s;
    assign out_fall = out_q & ~out_s;
    assign out_rise = ~out_q & out_s;

    // Both-low only counts once some frame is involved, so the post-reset select state is not a collision.
    assign collision = ~in_s & ~out_s &
                       ((rd_state == RD_SHIFT) || (wr_state != WR_IDLE) || in_fall || out_fall);
    assign rd_bad    = (rd_state == RD_SHIFT) && in_rise && (rd_cnt != CNT_FULL);
    assign wr_bad    = (wr_state == WR_SHIFT) && out_rise && (wr_cnt != CNT_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            rd_cnt   <= '0;
            tx       <= '0;
            rd_done  <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            case (rd_state)
                RD_IDLE: begin
                    if (in_fall) begin
                        tx       <= pv;
                        rd_cnt   <= '0;
                        rd_state <= RD_SHIFT;
                    end
                end
                default: begin
                    if (in_rise) begin
                        rd_state <= RD_IDLE;
                        rd_done  <= (rd_cnt == CNT_FULL);
                    end else if (sck_rise) begin
                        tx <= {tx[WIDTH-2:0], 1'b0};
                        if (rd_cnt != CNT_SAT) rd_cnt <= rd_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.miso = (rd_state == RD_SHIFT) && (rd_cnt < CNT_FULL) && tx[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            wr_cnt   <= '0;
            rx       <= '0;
            stim     <= '0;
            wr_done  <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (wr_state)
                WR_IDLE: begin
                    if (out_fall) begin
                        rx       <= '0;
                        wr_cnt   <= '0;
                        wr_state <= collision ? WR_ABORT : WR_SHIFT;
                    end
                end
                WR_SHIFT: begin
                    if (collision) begin
                        wr_state <= WR_ABORT;
                    end else if (out_rise) begin
                        wr_state <= WR_IDLE;
                        if (wr_cnt == CNT_FULL) begin
                            stim    <= rx;
                            wr_done <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        rx <= {rx[WIDTH-2:0], mosi_s};
                        if (wr_cnt != CNT_SAT) wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                default: begin
                    if (out_rise) wr_state <= WR_IDLE;
                end
            endcase
        end
    end

    // Arithmetic shift floors toward -inf; a zero step is forced to +/-1 so pv always lands on stim.
    always_comb begin
        diff = $signed({1'b0, stim}) - $signed({1'b0, pv});
        step = diff >>> SHIFT;
        if (step == '0 && diff != '0)
            step = diff[WIDTH] ? {(WIDTH+1){1'b1}} : {{WIDTH{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pv  <= pv_init;
            err <= 1'b0;
        end else begin
            if (wr_done) pv <= WIDTH'({1'b0, pv} + step);
            if (collision || rd_bad || wr_bad) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pid_plant_spi_slave.sv
// Directed bench for pid_plant_spi_slave: reads, plant convergence, bad frames, collision, reset mid-frame.
module tb_pid_plant_spi_slave;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pv_init;
    logic [3:0] pv, stim;
    logic       rd_done, wr_done, err;

    int tests = 0;
    int fails = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int rd0, wr0;
    logic       last_miso;
    logic [3:0] rdata;

    pid_plant_spi_slave_if bus();

    pid_plant_spi_slave #(.WIDTH(4), .SHIFT(1), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pv_init (pv_init),
        .pv      (pv),
        .stim    (stim),
        .rd_done (rd_done),
        .wr_done (wr_done),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_done) rd_pulses++;
        if (wr_done) wr_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic gap();
        half();
        repeat (4) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic m);
        bus.sck  = 1'b0;
        bus.mosi = m;
        half();
        bus.sck   = 1'b1;
        last_miso = bus.miso;
        half();
    endtask

    task automatic spi_read(output logic [3:0] d);
        d = '0;
        bus.in_cs_n = 1'b0;
        half();
        for (int i = 0; i < 4; i++) begin
            bit_xfer(1'b0);
            d = {d[2:0], last_miso};
        end
        bus.in_cs_n = 1'b1;
        gap();
    endtask

    task automatic spi_write(input logic [7:0] v, input int n);
        bus.out_cs_n = 1'b0;
        half();
        for (int i = n - 1; i >= 0; i--) bit_xfer(v[i]);
        bus.out_cs_n = 1'b1;
        gap();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.sck = 1'b1; bus.in_cs_n = 1'b1; bus.out_cs_n = 1'b1; bus.mosi = 1'b0;
        pv_init = 4'd3;
        do_reset();
        repeat (4) @(negedge clk);

        check("reset_pv", 32'(pv), 3);
        check("reset_stim", 32'(stim), 0);
        check("reset_err", 32'(err), 0);
        check("reset_miso", 32'(bus.miso), 0);
        check("reset_pulses", 32'(rd_pulses + wr_pulses), 0);

        spi_read(rdata);
        check("read_pv3", 32'(rdata), 3);
        check("read_pv3_done", 32'(rd_pulses), 1);
        check("read_pv3_err", 32'(err), 0);

        wr0 = wr_pulses;
        spi_write(8'hB, 4);
        check("wr_B_done", 32'(wr_pulses - wr0), 1);
        check("wr_B_stim", 32'(stim), 11);
        check("wr_B_pv1", 32'(pv), 7);
        spi_write(8'hB, 4);
        check("wr_B_pv2", 32'(pv), 9);
        spi_write(8'hB, 4);
        check("wr_B_pv3", 32'(pv), 10);
        spi_write(8'hB, 4);
        check("wr_B_pv4_unit", 32'(pv), 11);
        spi_write(8'hB, 4);
        check("wr_B_pv5_hold", 32'(pv), 11);
        check("wr_B_count", 32'(wr_pulses - wr0), 5);

        spi_read(rdata);
        check("read_pv11", 32'(rdata), 11);

        spi_write(8'h0, 4);
        check("wr_0_stim", 32'(stim), 0);
        check("wr_0_pv1", 32'(pv), 5);
        spi_write(8'h0, 4);
        check("wr_0_pv2", 32'(pv), 2);
        spi_write(8'h0, 4);
        check("wr_0_pv3", 32'(pv), 1);
        spi_write(8'h0, 4);
        check("wr_0_pv4", 32'(pv), 0);
        spi_write(8'h0, 4);
        check("wr_0_pv5_floor", 32'(pv), 0);
        check("pre_short_err", 32'(err), 0);

        wr0 = wr_pulses;
        spi_write(8'h7, 3);
        check("short_stim", 32'(stim), 0);
        check("short_nodone", 32'(wr_pulses - wr0), 0);
        check("short_err", 32'(err), 1);
        spi_write(8'h1F, 5);
        check("long_stim", 32'(stim), 0);
        check("long_nodone", 32'(wr_pulses - wr0), 0);
        check("long_pv", 32'(pv), 0);

        do_reset();
        check("reset2_err", 32'(err), 0);
        check("reset2_pv", 32'(pv), 3);
        spi_write(8'h5, 4);
        check("wr_5_stim", 32'(stim), 5);
        check("wr_5_pv", 32'(pv), 4);

        rd0 = rd_pulses;
        wr0 = wr_pulses;
        bus.out_cs_n = 1'b0;
        half();
        bit_xfer(1'b1);
        bit_xfer(1'b1);
        bus.in_cs_n = 1'b0;
        half();
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            bit_xfer(1'b1);
            rdata = {rdata[2:0], last_miso};
        end
        bus.in_cs_n = 1'b1;
        half();
        bus.out_cs_n = 1'b1;
        gap();
        check("coll_read", 32'(rdata), 4);
        check("coll_rd_done", 32'(rd_pulses - rd0), 1);
        check("coll_err", 32'(err), 1);
        check("coll_stim", 32'(stim), 5);
        check("coll_nodone", 32'(wr_pulses - wr0), 0);
        check("coll_pv", 32'(pv), 4);

        bus.out_cs_n = 1'b0;
        half();
        bit_xfer(1'b1);
        bit_xfer(1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wr0 = wr_pulses;
        bit_xfer(1'b1);
        bit_xfer(1'b1);
        bus.out_cs_n = 1'b1;
        gap();
        check("rstmid_stim", 32'(stim), 0);
        check("rstmid_pv", 32'(pv), 3);
        check("rstmid_nodone", 32'(wr_pulses - wr0), 0);
        check("rstmid_err", 32'(err), 0);

        spi_write(8'h6, 4);
        check("recover_stim", 32'(stim), 6);
        check("recover_pv", 32'(pv), 4);
        check("recover_done", 32'(wr_pulses - wr0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
